// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 valid-mode convolution over a raster-order
// unsigned 8-bit image, using a preloaded 9-tap signed kernel. Produces a
// (IN_WIDTH-2)x(IN_HEIGHT-2) signed 22-bit feature map in raster order with a
// one-cycle result_valid strobe and a done pulse at the end of each frame.
module conv3x3_stream #(
    parameter int IN_WIDTH  = 34,
    parameter int IN_HEIGHT = 34
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               weight_valid,
    input  logic signed [7:0]  weight_in,
    output logic               weights_loaded,
    input  logic               start_signal,
    input  logic               pixel_valid,
    input  logic [7:0]         pixel_in,
    output logic signed [21:0] result_out,
    output logic               result_valid,
    output logic               done_signal
);

    localparam int XW = $clog2(IN_WIDTH);
    localparam int YW = $clog2(IN_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(2);
    localparam logic [YW-1:0] Y_MIN  = YW'(2);

    typedef enum logic [1:0] {IDLE, PROCESSING, DONE} state_t;

    state_t state, state_nxt;

    logic signed [7:0] taps [9];
    logic [3:0]        wcnt;

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    // Line buffers: lb1 holds row y-1, lb2 holds row y-2, indexed by column.
    logic [7:0] lb1 [IN_WIDTH];
    logic [7:0] lb2 [IN_WIDTH];

    // Window history: columns x-2 and x-1 of the three rows; the third column
    // of the 3x3 window is the incoming column (lb2[x], lb1[x], pixel_in).
    logic [7:0] win [3][2];
    logic [7:0] col_p0 [3];

    logic               accept_p0;
    logic               last_px_p0;
    logic               vld_p0;
    logic signed [21:0] sum_p0;

    logic signed [21:0] result_p1;
    logic               vld_p1;

    // Pixel zero-extended to 9-bit signed, times 8-bit signed tap -> 17 bits.
    function automatic logic signed [16:0] tap_mul(input logic [7:0] pix,
                                                   input logic signed [7:0] k);
        logic signed [16:0] pe;
        logic signed [16:0] ke;
        pe = {9'd0, pix};
        ke = {{9{k[7]}}, k};
        return pe * ke;
    endfunction

    // Sign-extend a product to the 22-bit accumulator width.
    function automatic logic signed [21:0] ext_acc(input logic signed [16:0] p);
        return {{5{p[16]}}, p};
    endfunction

    assign accept_p0  = (state == PROCESSING) && pixel_valid;
    assign last_px_p0 = accept_p0 && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign vld_p0     = accept_p0 && (x_cnt >= X_MIN) && (y_cnt >= Y_MIN);

    assign col_p0[0] = lb2[x_cnt];
    assign col_p0[1] = lb1[x_cnt];
    assign col_p0[2] = pixel_in;

    // ---- stage p0: window formed from history plus incoming column ----
    // Nine-tap multiply-accumulate over the window that includes this pixel.
    always_comb begin
        sum_p0 = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum_p0 = sum_p0 + ext_acc(tap_mul((c == 2) ? col_p0[r] : win[r][c],
                                                  taps[r*3 + c]));
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start_signal && weights_loaded) state_nxt = PROCESSING;
            PROCESSING: if (last_px_p0) state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign done_signal = (state == DONE);

    // Kernel loading; a write after a full kernel starts a fresh load at tap 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt           <= '0;
            weights_loaded <= 1'b0;
            for (int i = 0; i < 9; i++) taps[i] <= '0;
        end else if (state == IDLE && weight_valid) begin
            if (wcnt == 4'd9) begin
                taps[0]        <= weight_in;
                wcnt           <= 4'd1;
                weights_loaded <= 1'b0;
            end else begin
                taps[wcnt] <= weight_in;
                wcnt       <= wcnt + 4'd1;
                if (wcnt == 4'd8) weights_loaded <= 1'b1;
            end
        end
    end

    // Raster position of the next pixel; cleared when a frame starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (state == IDLE && state_nxt == PROCESSING) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accept_p0) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    // Line buffers and window shift, advanced only on an accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= '0;
                win[r][1] <= '0;
            end
        end else if (accept_p0) begin
            lb2[x_cnt] <= lb1[x_cnt];
            lb1[x_cnt] <= pixel_in;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= col_p0[r];
            end
        end
    end

    // ---- stage p1: registered result, held between strobes ----
    // Capture the sum one cycle after a qualifying pixel is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) result_p1 <= sum_p0;
        end
    end

    assign result_out   = result_p1;
    assign result_valid = vld_p1;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed testbench for conv3x3_stream: kernel loading, identity and
// extreme-value frames, stalled input, and mid-frame reset.
module tb_conv3x3_stream;

    localparam int W    = 34;
    localparam int H    = 34;
    localparam int NOUT = (W - 2) * (H - 2);

    logic               clk = 1'b0;
    logic               rst;
    logic               weight_valid;
    logic signed [7:0]  weight_in;
    logic               weights_loaded;
    logic               start_signal;
    logic               pixel_valid;
    logic [7:0]         pixel_in;
    logic signed [21:0] result_out;
    logic               result_valid;
    logic               done_signal;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rv_cnt = 0;
    int done_cnt = 0;
    int first_seen = 0;
    int first_rv_cyc = 0;
    int drive_cyc = 0;
    int exp_q[$];
    int kmodel[9];

    conv3x3_stream #(.IN_WIDTH(W), .IN_HEIGHT(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .weight_valid  (weight_valid),
        .weight_in     (weight_in),
        .weights_loaded(weights_loaded),
        .start_signal  (start_signal),
        .pixel_valid   (pixel_valid),
        .pixel_in      (pixel_in),
        .result_out    (result_out),
        .result_valid  (result_valid),
        .done_signal   (done_signal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int img(input int x, input int y, input int mode);
        return (mode == 0) ? ((x + 34 * y) % 256) : 255;
    endfunction

    function automatic int model(input int x, input int y, input int mode);
        int s;
        s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += kmodel[r*3 + c] * img(x - 2 + c, y - 2 + r, mode);
        return s;
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (result_valid) begin
            rv_cnt++;
            if (first_seen == 0) begin
                first_seen   = 1;
                first_rv_cyc = cyc;
            end
            if (exp_q.size() == 0) chk("extra_result", 1, 0);
            else                   chk("result", result_out, exp_q.pop_front());
        end
        if (done_signal) begin
            done_cnt++;
            chk("done_with_last_result", result_valid, 1);
            chk("done_queue_empty", exp_q.size(), 0);
        end
    end

    task automatic load_w(input int v);
        weight_valid = 1'b1;
        weight_in    = 8'(v);
        @(posedge clk); #1;
        weight_valid = 1'b0;
    endtask

    task automatic load_kernel();
        for (int i = 0; i < 9; i++) load_w(kmodel[i]);
    endtask

    task automatic set_kernel(input int v);
        for (int i = 0; i < 9; i++) kmodel[i] = v;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 9; i++) kmodel[i] = (i == 4) ? 1 : 0;
    endtask

    task automatic pulse_start();
        start_signal = 1'b1;
        @(posedge clk); #1;
        start_signal = 1'b0;
    endtask

    // Start a frame and stream pixels; use_c pushes the constant cval as the
    // expected result instead of the model. abort_after>0 stops early.
    task automatic run_frame(input int mode, input bit gaps, input int abort_after,
                             input bit use_c, input int cval);
        int  n;
        bit  stop;
        n = 0;
        stop = 1'b0;
        rv_cnt = 0;
        done_cnt = 0;
        first_seen = 0;
        pulse_start();
        for (int y = 0; y < H && !stop; y++) begin
            for (int x = 0; x < W && !stop; x++) begin
                if (gaps) begin
                    for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++) begin
                        pixel_valid = 1'b0;
                        pixel_in    = 8'hA5;
                        @(posedge clk); #1;
                    end
                end
                pixel_valid = 1'b1;
                pixel_in    = 8'(img(x, y, mode));
                if (x >= 2 && y >= 2) exp_q.push_back(use_c ? cval : model(x, y, mode));
                if (x == 2 && y == 2) drive_cyc = cyc;
                @(posedge clk); #1;
                n++;
                if (abort_after > 0 && n == abort_after) stop = 1'b1;
            end
        end
        pixel_valid = 1'b0;
        if (abort_after == 0) begin
            for (int i = 0; i < 20 && done_cnt == 0; i++) begin
                @(posedge clk); #1;
            end
            repeat (3) @(posedge clk);
            #1;
            chk("frame_results", rv_cnt, NOUT);
            chk("done_pulses", done_cnt, 1);
            chk("first_result_latency", first_rv_cyc - drive_cyc, 1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        weight_valid = 1'b0;
        weight_in    = '0;
        start_signal = 1'b0;
        pixel_valid  = 1'b0;
        pixel_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_out", result_out, 0);
        chk("rst_done", done_signal, 0);
        chk("rst_weights_loaded", weights_loaded, 0);

        // Start with no kernel loaded is ignored, as are pixels.
        pixel_valid = 1'b1;
        pixel_in    = 8'd77;
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        chk("nowt_results", rv_cnt, 0);
        chk("nowt_done", done_cnt, 0);

        // Load sequencing, including restart on a 10th write.
        for (int i = 0; i < 8; i++) load_w(5);
        chk("wl_after_8", weights_loaded, 0);
        load_w(5);
        chk("wl_after_9", weights_loaded, 1);
        load_w(0);
        chk("wl_restart", weights_loaded, 0);
        for (int i = 1; i < 8; i++) load_w((i == 4) ? 1 : 0);
        chk("wl_after_restart_7", weights_loaded, 0);
        load_w(0);
        chk("wl_after_restart_8", weights_loaded, 1);
        set_identity();

        // Identity kernel on the ramp image; tap 0 must hold the restart value.
        run_frame(0, 1'b0, 0, 1'b0, 0);

        set_kernel(-128);
        load_kernel();
        run_frame(1, 1'b0, 0, 1'b1, -293760);

        set_kernel(127);
        load_kernel();
        run_frame(1, 1'b0, 0, 1'b1, 291465);

        set_identity();
        load_kernel();
        run_frame(0, 1'b1, 0, 1'b0, 0);

        // Abort after 500 accepted pixels: 12 full output rows + 22 = 406.
        run_frame(0, 1'b0, 500, 1'b0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_results_before_rst", rv_cnt, 406);
        chk("abort_queue_drained", exp_q.size(), 0);
        chk("abort_result_valid", result_valid, 0);
        chk("abort_result_out", result_out, 0);
        chk("abort_done", done_signal, 0);
        chk("abort_weights_loaded", weights_loaded, 0);
        exp_q.delete();
        rv_cnt   = 0;
        done_cnt = 0;
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        chk("abort_idle_results", rv_cnt, 0);
        chk("abort_idle_done", done_cnt, 0);

        set_identity();
        load_kernel();
        run_frame(0, 1'b0, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
